// File: rtl/i2s_tx.sv
// ============================================================================
// i2s_tx : I2S master transmitter, 16-bit mono sample duplicated to both
//          channels, 64 SCK per frame, programmable SCK half-period.
// Rev 1.0
// ============================================================================
`default_nettype none

module i2s_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sck_period,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  input  logic [15:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic        underrun
);

  logic [7:0]  ccnt;
  logic [6:0]  bcnt;
  logic [15:0] hold;
  logic        hold_vld;
  logic [15:0] frame_word;

  logic [8:0]  period_eff;
  logic        bcnt_inc;
  logic [6:0]  bcnt_nxt;
  logic        sck_fall;
  logic        frame_start;
  logic        accept;
  logic        in_slot;
  logic [3:0]  bit_idx;
  logic        sd_nxt;

  always_comb begin
    period_eff  = (sck_period == 8'd0) ? 9'd1 : {1'b0, sck_period};
    // >= (not ==) so a period shrunk below the running count ends the half-period at once
    bcnt_inc    = (({1'b0, ccnt} + 9'd1) >= period_eff);
    bcnt_nxt    = bcnt + 7'd1;
    sck_fall    = bcnt_inc & bcnt[0];
    frame_start = bcnt_inc & (bcnt == 7'd127);
    accept      = din_vld & ~hold_vld;

    // Data slots are even bcnt 2..32 in each half-frame; bit index is 16 - bcnt/2 (mod 16)
    in_slot = (bcnt_nxt[5:0] >= 6'd2) && (bcnt_nxt[5:0] <= 6'd32);
    bit_idx = 4'd0 - bcnt_nxt[4:1];
    sd_nxt  = in_slot ? frame_word[bit_idx] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt       <= 8'd0;
      bcnt       <= 7'd0;
      sd         <= 1'b0;
      underrun   <= 1'b0;
      frame_word <= 16'd0;
      hold       <= 16'd0;
      hold_vld   <= 1'b0;
    end else begin
      if (bcnt_inc) begin
        ccnt <= 8'd0;
        bcnt <= bcnt_nxt;
      end else begin
        ccnt <= ccnt + 8'd1;
      end

      if (sck_fall) begin
        sd <= sd_nxt;
      end

      underrun <= frame_start & ~hold_vld;

      if (frame_start) begin
        frame_word <= hold_vld ? hold : 16'd0;
      end

      // A frame start with an empty holding register may still accept a new word
      if (frame_start && hold_vld) begin
        hold_vld <= 1'b0;
      end else if (accept) begin
        hold     <= din;
        hold_vld <= 1'b1;
      end
    end
  end

  assign sck     = bcnt[0];
  assign ws      = bcnt[6];
  assign din_rdy = ~hold_vld;

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The module SHALL have no parameters; the sample width is fixed at 16 bits and each frame is 64 SCK periods.
REQ-002 clk  input  1  internal clock (~100 MHz, much faster than SCK).
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sck_period  input  8  SCK half-period in clk cycles; value 0 SHALL be treated as 1.
REQ-005 sck  output  1  serial clock to the DAC/codec.
REQ-006 ws  output  1  word select: 0 = left, 1 = right.
REQ-007 sd  output  1  serial data, MSB first.
REQ-008 din  input  16  sample to transmit.
REQ-009 din_vld  input  1  din valid.
REQ-010 din_rdy  output  1  holding register empty.
REQ-011 underrun  output  1  one-clk pulse when a frame starts with no sample available.

Function
REQ-012 Counter ccnt (8-bit) SHALL count clk cycles.
REQ-013 bcnt_inc SHALL be asserted when (ccnt+1) >= max(sck_period,1), evaluated at 9-bit width.
REQ-014 On bcnt_inc, ccnt SHALL clear to 0 and bcnt (7-bit) SHALL increment, wrapping 127->0; otherwise ccnt SHALL increment.
REQ-015 sck SHALL equal bcnt[0] and ws SHALL equal bcnt[6]; both SHALL be registered, with no combinational path from inputs.
REQ-016 Lowering sck_period below ccnt+1 SHALL cause bcnt to increment on the next clk; no stall and no 256-cycle wrap.
REQ-017 The SCK falling edge is the bcnt_inc cycle with bcnt odd; the frame-start cycle is the bcnt_inc cycle with bcnt==127.
REQ-018 Input buffering: a 16-bit holding register with flag hold_vld; din_rdy SHALL equal ~hold_vld.
REQ-019 Accept: a transfer SHALL occur when din_vld & din_rdy, loading din into the holding register and setting hold_vld the next clk.
REQ-020 din_vld SHALL be ignored while din_rdy=0, with no overwrite.
REQ-021 At frame start with hold_vld=1: frame_word <= hold register and hold_vld <= 0.
REQ-022 A transfer in that same cycle is impossible, since din_rdy=0.
REQ-023 At frame start with hold_vld=0: frame_word <= 0 and underrun SHALL pulse high for exactly that one clk.
REQ-024 At frame start with hold_vld=0, a transfer occurring in that same cycle SHALL go to the holding register and be used at the next frame start; there is no bypass.
REQ-025 The same frame_word SHALL be transmitted on both channels (mono duplicated to stereo).
REQ-026 sd SHALL change only on SCK falling edges.
REQ-027 Entering bcnt=2+2k or 66+2k (k=0..15), sd SHALL be set to frame_word[15-k].
REQ-028 Entering any other bcnt, sd SHALL be set to 0, i.e. the MSB follows the ws transition by one SCK and trailing slots are zero.
REQ-029 As a consequence, a receiver sampling at the end of even bcnt 66..96 SHALL capture frame_word exactly.
REQ-030 Latency from accept to MSB on sd SHALL be at most 2 frames + 2 SCK periods.

Reset
REQ-031 While rst_n=0 (asynchronously), ccnt, bcnt, frame_word, the holding register and hold_vld SHALL be 0.
REQ-032 While rst_n=0, sck=0, ws=0, sd=0 and underrun=0.
REQ-033 While rst_n=0, din_rdy SHALL be 1.
REQ-034 Reset mid-frame SHALL discard the held and in-flight samples with no partial-word completion.
REQ-035 After release, the first SCK rise SHALL occur max(sck_period,1) clks later, and the first frame start SHALL transmit zeros with underrun pulsed unless a sample was accepted first.

Verification
REQ-036 Directed scenario: sck_period=4; din=16'hA5C3 accepted before the first frame start -> sck period 8 clk, frame 512 clk; sd carries A5C3 MSB-first at bcnt 2..32 (ws=0) and 66..96 (ws=1); sd=0 elsewhere; underrun is not pulsed in that frame.
REQ-037 Directed scenario: din_vld held at 0 -> every frame is all zeros and underrun pulses once per 128 bcnt steps, exactly 1 clk wide, at bcnt 127->0.
REQ-038 Directed scenario: din_vld held at 1 with words 1111, 2222, 3333 -> din_rdy falls the clk after each accept and rises the clk after each frame start; the words appear on consecutive frames in order, none lost or repeated.
REQ-039 Directed scenario: loopback into i2s_rx (same clk, rst_n, sck_period=6; rx sd = tx sd) -> rx dout equals each transmitted word and dout_vld asserts once per frame.
REQ-040 Directed scenario: rst_n pulsed low at bcnt=70 with a word held -> outputs drop to 0 asynchronously; after release, din_rdy=1 and the next frame is zeros with an underrun pulse.
REQ-041 Directed scenario: sck_period changed 8->3 while ccnt=5 -> bcnt increments on the next clk and subsequent half-periods are 3 clk.
